// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FSM controller for the shared-memory multi-cycle RV32I datapath
module multicycle_control_unit #(
    parameter int MEM_WAIT_EN = 1,
    parameter int CNT_W       = 32,
    parameter int JAL_EN      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       imm_src,
    output logic [2:0]       alu_control,
    output logic             reg_write,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] retired_cnt
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL, ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    state_t     state, next_state;
    logic       ready;
    logic       retire;
    logic [1:0] alu_op;
    logic [2:0] funct_ctl;
    logic       unused_funct7;

    // Only funct7[5] distinguishes sub from add; the other bits are don't-care here.
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // With the wait handshake disabled every memory access completes in one cycle.
    assign ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

    // An instruction retires when its final state hands control back to FETCH.
    assign retire = (next_state == FETCH) &&
                    (state == MEMWB || state == MEMWRITE || state == ALUWB || state == BEQ);

    // Immediate format depends only on the opcode held in IR.
    assign imm_src = (op == OP_SW)  ? 2'b01 :
                     (op == OP_BEQ) ? 2'b10 :
                     (op == OP_JAL) ? 2'b11 : 2'b00;

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= FETCH;
        else
            state <= next_state;
    end

    // Retired-instruction counter, wrapping naturally at its width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retired_cnt <= '0;
        else if (retire)
            retired_cnt <= retired_cnt + CNT_W'(1);
    end

    // Next-state sequencing, including memory stalls and opcode dispatch.
    always_comb begin
        next_state = state;
        case (state)
            FETCH:    next_state = ready ? DECODE : FETCH;
            DECODE: begin
                if (op == OP_LW || op == OP_SW)
                    next_state = MEMADR;
                else if (op == OP_R)
                    next_state = EXECR;
                else if (op == OP_I)
                    next_state = EXECI;
                else if (op == OP_BEQ)
                    next_state = BEQ;
                else if (op == OP_JAL && JAL_EN != 0)
                    next_state = JAL;
                else
                    next_state = ILLEGAL;
            end
            MEMADR:   next_state = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  next_state = ready ? MEMWB : MEMREAD;
            MEMWB:    next_state = FETCH;
            MEMWRITE: next_state = ready ? FETCH : MEMWRITE;
            EXECR:    next_state = ALUWB;
            EXECI:    next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            BEQ:      next_state = FETCH;
            JAL:      next_state = ALUWB;
            ILLEGAL:  next_state = FETCH;
            default:  next_state = FETCH;
        endcase
    end

    // Moore datapath controls; pc_write also folds in mem_ready and the zero flag.
    always_comb begin
        pc_write      = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = ALU_ADD;
        reg_write     = 1'b0;
        illegal_instr = 1'b0;
        case (state)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = ready;
                pc_write   = ready;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = ALU_FUNCT;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = ALU_FUNCT;
            end
            ALUWB:    reg_write = 1'b1;
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = ALU_SUB;
                pc_write  = zero;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            ILLEGAL:  illegal_instr = 1'b1;
            default:  illegal_instr = 1'b0;
        endcase
    end

    // ALU function from funct fields; sub only for R-type with funct7[5] set.
    always_comb begin
        funct_ctl = 3'b000;
        case (funct3)
            3'b000:  funct_ctl = (op[5] & funct7[5]) ? 3'b001 : 3'b000;
            3'b010:  funct_ctl = 3'b101;
            3'b110:  funct_ctl = 3'b011;
            3'b111:  funct_ctl = 3'b010;
            default: funct_ctl = 3'b000;
        endcase
    end

    // Final ALU control selection from the state-driven ALU operation.
    always_comb begin
        alu_control = (alu_op == ALU_SUB)   ? 3'b001 :
                      (alu_op == ALU_FUNCT) ? funct_ctl : 3'b000;
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: cycle-by-cycle scoreboard check of the multi-cycle controller
module tb_multicycle_control_unit;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b0000000;

    typedef struct {
        string       name;
        logic [16:0] ctl;
        logic [31:0] cnt;
        logic        sel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst2 = 1'b1;
    logic [6:0]  op = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [6:0]  funct7 = 7'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;

    logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0]  alu_control;
    logic [31:0] retired_cnt;

    logic        pc_write2, adr_src2, mem_write2, ir_write2, reg_write2, illegal_instr2;
    logic [1:0]  result_src2, alu_src_a2, alu_src_b2, imm_src2;
    logic [2:0]  alu_control2;
    logic [3:0]  retired_cnt2;

    exp_t        q[$];
    exp_t        e;
    logic [16:0] act_ctl;
    logic [31:0] act_cnt;
    int          total = 0;
    int          bad = 0;

    multicycle_control_unit dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control),
        .reg_write(reg_write), .illegal_instr(illegal_instr), .retired_cnt(retired_cnt)
    );

    multicycle_control_unit #(.MEM_WAIT_EN(0), .CNT_W(4), .JAL_EN(0)) dut2 (
        .clk(clk), .rst(rst2), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write2), .adr_src(adr_src2), .mem_write(mem_write2),
        .ir_write(ir_write2), .result_src(result_src2), .alu_src_a(alu_src_a2),
        .alu_src_b(alu_src_b2), .imm_src(imm_src2), .alu_control(alu_control2),
        .reg_write(reg_write2), .illegal_instr(illegal_instr2), .retired_cnt(retired_cnt2)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] v(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] imm, input logic [2:0] ac,
                                      input logic rw, input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sb, imm, ac, rw, ill};
    endfunction

    task automatic step(input string nm, input logic [6:0] o, input logic [2:0] f3,
                        input logic f7b, input logic z, input logic rdy, input logic r,
                        input logic [16:0] ctl, input logic [31:0] c, input logic s);
        exp_t x;
        @(posedge clk);
        #1;
        op = o;
        funct3 = f3;
        funct7 = {1'b0, f7b, 5'b0};
        zero = z;
        mem_ready = rdy;
        if (s) rst2 = r;
        else rst = r;
        x.name = nm;
        x.ctl = ctl;
        x.cnt = c;
        x.sel = s;
        q.push_back(x);
    endtask

    // Monitor: the controller presents a full control word every cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            act_ctl = e.sel ?
                {pc_write2, adr_src2, mem_write2, ir_write2, result_src2, alu_src_a2,
                 alu_src_b2, imm_src2, alu_control2, reg_write2, illegal_instr2} :
                {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                 alu_src_b, imm_src, alu_control, reg_write, illegal_instr};
            act_cnt = e.sel ? {28'd0, retired_cnt2} : retired_cnt;
            total++;
            if (act_ctl !== e.ctl) begin
                bad++;
                $display("FAIL %s ctl got=%b want=%b", e.name, act_ctl, e.ctl);
            end
            total++;
            if (act_cnt !== e.cnt) begin
                bad++;
                $display("FAIL %s retired_cnt got=%0d want=%0d", e.name, act_cnt, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        step("reset",   LW, 3'd2, 0, 0, 0, 1, v(0,0,0,0,2,0,2,0,0,0,0), 0, 0);
        step("lw_f",    LW, 3'd2, 0, 0, 1, 0, v(1,0,0,1,2,0,2,0,0,0,0), 0, 0);
        step("lw_d",    LW, 3'd2, 0, 0, 1, 0, v(0,0,0,0,0,1,1,0,0,0,0), 0, 0);
        step("lw_ma",   LW, 3'd2, 0, 0, 1, 0, v(0,0,0,0,0,2,1,0,0,0,0), 0, 0);
        step("lw_mr",   LW, 3'd2, 0, 0, 1, 0, v(0,1,0,0,0,0,0,0,0,0,0), 0, 0);
        step("lw_wb",   LW, 3'd2, 0, 0, 1, 0, v(0,0,0,0,1,0,0,0,0,1,0), 0, 0);
        step("sub_f",   RT, 3'd0, 1, 0, 1, 0, v(1,0,0,1,2,0,2,0,0,0,0), 1, 0);
        step("sub_d",   RT, 3'd0, 1, 0, 1, 0, v(0,0,0,0,0,1,1,0,0,0,0), 1, 0);
        step("sub_ex",  RT, 3'd0, 1, 0, 1, 0, v(0,0,0,0,0,2,0,0,1,0,0), 1, 0);
        step("sub_wb",  RT, 3'd0, 1, 0, 1, 0, v(0,0,0,0,0,0,0,0,0,1,0), 1, 0);
        step("and_f",   RT, 3'd7, 0, 0, 1, 0, v(1,0,0,1,2,0,2,0,0,0,0), 2, 0);
        step("and_d",   RT, 3'd7, 0, 0, 1, 0, v(0,0,0,0,0,1,1,0,0,0,0), 2, 0);
        step("and_ex",  RT, 3'd7, 0, 0, 1, 0, v(0,0,0,0,0,2,0,0,2,0,0), 2, 0);
        step("and_wb",  RT, 3'd7, 0, 0, 1, 0, v(0,0,0,0,0,0,0,0,0,1,0), 2, 0);
        step("slt_f",   RT, 3'd2, 0, 0, 1, 0, v(1,0,0,1,2,0,2,0,0,0,0), 3, 0);
        step("slt_d",   RT, 3'd2, 0, 0, 1, 0, v(0,0,0,0,0,1,1,0,0,0,0), 3, 0);
        step("slt_ex",  RT, 3'd2, 0, 0, 1, 0, v(0,0,0,0,0,2,0,0,5,0,0), 3, 0);
        step("slt_wb",  RT, 3'd2, 0, 0, 1, 0, v(0,0,0,0,0,0,0,0,0,1,0), 3, 0);
        step("addi_f",  IT, 3'd0, 1, 0, 1, 0, v(1,0,0,1,2,0,2,0,0,0,0), 4, 0);
        step("addi_d",  IT, 3'd0, 1, 0, 1, 0, v(0,0,0,0,0,1,1,0,0,0,0), 4, 0);
        step("addi_ex", IT, 3'd0, 1, 0, 1, 0, v(0,0,0,0,0,2,1,0,0,0,0), 4, 0);
        step("addi_wb", IT, 3'd0, 1, 0, 1, 0, v(0,0,0,0,0,0,0,0,0,1,0), 4, 0);
        step("beq1_f",  BQ, 3'd0, 0, 1, 1, 0, v(1,0,0,1,2,0,2,2,0,0,0), 5, 0);
        step("beq1_d",  BQ, 3'd0, 0, 1, 1, 0, v(0,0,0,0,0,1,1,2,0,0,0), 5, 0);
        step("beq1_b",  BQ, 3'd0, 0, 1, 1, 0, v(1,0,0,0,0,2,0,2,1,0,0), 5, 0);
        step("beq0_f",  BQ, 3'd0, 0, 0, 1, 0, v(1,0,0,1,2,0,2,2,0,0,0), 6, 0);
        step("beq0_d",  BQ, 3'd0, 0, 0, 1, 0, v(0,0,0,0,0,1,1,2,0,0,0), 6, 0);
        step("beq0_b",  BQ, 3'd0, 0, 0, 1, 0, v(0,0,0,0,0,2,0,2,1,0,0), 6, 0);
        step("jal_f",   JL, 3'd0, 0, 0, 1, 0, v(1,0,0,1,2,0,2,3,0,0,0), 7, 0);
        step("jal_d",   JL, 3'd0, 0, 0, 1, 0, v(0,0,0,0,0,1,1,3,0,0,0), 7, 0);
        step("jal_j",   JL, 3'd0, 0, 0, 1, 0, v(1,0,0,0,0,1,2,3,0,0,0), 7, 0);
        step("jal_wb",  JL, 3'd0, 0, 0, 1, 0, v(0,0,0,0,0,0,0,3,0,1,0), 7, 0);
        step("ill_f",   BAD, 3'd0, 0, 0, 1, 0, v(1,0,0,1,2,0,2,0,0,0,0), 8, 0);
        step("ill_d",   BAD, 3'd0, 0, 0, 1, 0, v(0,0,0,0,0,1,1,0,0,0,0), 8, 0);
        step("ill_x",   BAD, 3'd0, 0, 0, 1, 0, v(0,0,0,0,0,0,0,0,0,0,1), 8, 0);
        for (int i = 0; i < 3; i++)
            step("sw_fwait", SW, 3'd2, 0, 0, 0, 0, v(0,0,0,0,2,0,2,1,0,0,0), 8, 0);
        step("sw_f",    SW, 3'd2, 0, 0, 1, 0, v(1,0,0,1,2,0,2,1,0,0,0), 8, 0);
        step("sw_d",    SW, 3'd2, 0, 0, 1, 0, v(0,0,0,0,0,1,1,1,0,0,0), 8, 0);
        step("sw_ma",   SW, 3'd2, 0, 0, 1, 0, v(0,0,0,0,0,2,1,1,0,0,0), 8, 0);
        for (int i = 0; i < 3; i++)
            step("sw_mwait", SW, 3'd2, 0, 0, 0, 0, v(0,1,1,0,0,0,0,1,0,0,0), 8, 0);
        step("sw_mw",   SW, 3'd2, 0, 0, 1, 0, v(0,1,1,0,0,0,0,1,0,0,0), 8, 0);
        step("lw2_f",   LW, 3'd2, 0, 0, 1, 0, v(1,0,0,1,2,0,2,0,0,0,0), 9, 0);
        step("lw2_d",   LW, 3'd2, 0, 0, 1, 0, v(0,0,0,0,0,1,1,0,0,0,0), 9, 0);
        step("lw2_ma",  LW, 3'd2, 0, 0, 1, 0, v(0,0,0,0,0,2,1,0,0,0,0), 9, 0);
        step("lw2_mr",  LW, 3'd2, 0, 0, 0, 0, v(0,1,0,0,0,0,0,0,0,0,0), 9, 0);
        step("lw2_mr",  LW, 3'd2, 0, 0, 0, 0, v(0,1,0,0,0,0,0,0,0,0,0), 9, 0);
        step("mid_rst", LW, 3'd2, 0, 0, 0, 1, v(0,0,0,0,2,0,2,0,0,0,0), 0, 0);
        step("post_rst", LW, 3'd2, 0, 0, 0, 0, v(0,0,0,0,2,0,2,0,0,0,0), 0, 0);
        step("add_f",   RT, 3'd0, 0, 0, 1, 0, v(1,0,0,1,2,0,2,0,0,0,0), 0, 0);
        step("add_d",   RT, 3'd0, 0, 0, 1, 0, v(0,0,0,0,0,1,1,0,0,0,0), 0, 0);
        step("add_ex",  RT, 3'd0, 0, 0, 1, 0, v(0,0,0,0,0,2,0,0,0,0,0), 0, 0);
        step("add_wb",  RT, 3'd0, 0, 0, 1, 0, v(0,0,0,0,0,0,0,0,0,1,0), 0, 0);
        step("add_next", RT, 3'd0, 0, 0, 0, 0, v(0,0,0,0,2,0,2,0,0,0,0), 1, 0);
        for (int i = 0; i < 15; i++) begin
            step("w_beq_f", BQ, 3'd0, 0, 0, 0, 0, v(1,0,0,1,2,0,2,2,0,0,0), 32'(i), 1);
            step("w_beq_d", BQ, 3'd0, 0, 0, 0, 0, v(0,0,0,0,0,1,1,2,0,0,0), 32'(i), 1);
            step("w_beq_b", BQ, 3'd0, 0, 0, 0, 0, v(0,0,0,0,0,2,0,2,1,0,0), 32'(i), 1);
        end
        step("nojal_f", JL, 3'd0, 0, 0, 0, 0, v(1,0,0,1,2,0,2,3,0,0,0), 15, 1);
        step("nojal_d", JL, 3'd0, 0, 0, 0, 0, v(0,0,0,0,0,1,1,3,0,0,0), 15, 1);
        step("nojal_x", JL, 3'd0, 0, 0, 0, 0, v(0,0,0,0,0,0,0,3,0,0,1), 15, 1);
        step("wrap_f",  BQ, 3'd0, 0, 1, 0, 0, v(1,0,0,1,2,0,2,2,0,0,0), 15, 1);
        step("wrap_d",  BQ, 3'd0, 0, 1, 0, 0, v(0,0,0,0,0,1,1,2,0,0,0), 15, 1);
        step("wrap_b",  BQ, 3'd0, 0, 1, 0, 0, v(1,0,0,0,0,2,0,2,1,0,0), 15, 1);
        step("wrap_0",  BQ, 3'd0, 0, 1, 0, 0, v(1,0,0,1,2,0,2,2,0,0,0), 0, 1);
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle RV32I control decode.
- FSM sequences each instruction over 3–5 cycles: FETCH, DECODE, execute, memory, writeback.
- Drives the shared-memory multi-cycle datapath (PC, OldPC, IR, ALUOut, Data registers).
- Adds a memory wait handshake, illegal-opcode trapping and a retired-instruction counter.

Parameters:
- MEM_WAIT_EN, 1: 1 = FETCH/MEMREAD/MEMWRITE hold until mem_ready; 0 = mem_ready ignored, treated as 1.
- CNT_W, 32: width of the retired-instruction counter.
- JAL_EN, 1: 1 = opcode 1101111 supported; 0 = treated as illegal.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7  in  7  IR[31:25]; only bit 5 used.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  PC load enable.
- adr_src  out  1  0 = PC, 1 = ALUOut as memory address.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR and OldPC load enable.
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- alu_src_a  out  2  00 PC, 01 OldPC, 10 RD1.
- alu_src_b  out  2  00 RD2 (WriteData), 01 ImmExt, 10 constant 4.
- imm_src  out  2  00 I, 01 S, 10 B, 11 J.
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- reg_write  out  1  register file write enable.
- illegal_instr  out  1  one-cycle pulse on unsupported opcode.
- retired_cnt  out  CNT_W  completed-instruction count.

Behaviour:
- Reset: async on rst=1. State=FETCH, retired_cnt=0, illegal_instr=0.
- Outputs are combinational from state (Moore), except alu_control (state plus funct) and pc_write (branch & zero).
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, ILLEGAL.
- Default for every output is 0 unless listed below.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, ALUOp=add, result_src=10.
  - ir_write and pc_write assert only when mem_ready (or MEM_WAIT_EN=0); advance to DECODE in that cycle, otherwise stay.
- DECODE: alu_src_a=01, alu_src_b=01, ALUOp=add (branch target into ALUOut). Next state by op:
  - 0000011 → MEMADR; 0100011 → MEMADR
  - 0110011 → EXECR; 0010011 → EXECI
  - 1100011 → BEQ; 1101111 → JAL
  - anything else → ILLEGAL
- imm_src, valid from DECODE onward: S for 0100011, B for 1100011, J for 1101111, else I.
- MEMADR: alu_src_a=10, alu_src_b=01, add. Next: MEMREAD for load, MEMWRITE for store.
- MEMREAD: adr_src=1; hold until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: adr_src=1, mem_write=1 while waiting; FETCH in the mem_ready cycle.
- EXECR: alu_src_a=10, alu_src_b=00, ALUOp=funct. Next ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, ALUOp=funct. Next ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, ALUOp=sub, result_src=00; pc_write=zero. Next FETCH.
- JAL: alu_src_a=01, alu_src_b=10, ALUOp=add, result_src=00, pc_write=1. Next ALUWB (rd=OldPC+4).
- ILLEGAL: illegal_instr=1 for exactly that cycle, no writes, next FETCH; not counted as retired.
- ALU decode:
  - ALUOp add → 000; sub → 001.
  - funct: funct3 000 → sub (001) if op[5]&funct7[5], else add (000).
  - funct3 010 → 101; 110 → 011; 111 → 010; other funct3 → 000.
- Retirement: retired_cnt increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. Wraps modulo 2^CNT_W.
- Latencies with zero wait states: lw 5 cycles, sw 4, R/I 4, beq 3, jal 4.
- Reset mid-instruction aborts immediately: no partial write, counter cleared.
- mem_ready held low: the FSM stalls indefinitely with strobes held steady.

Test Plan:
- Reset: rst=1 mid-MEMREAD → state FETCH, retired_cnt=0, all strobes 0 next cycle.
- lw 0x00002083 with mem_ready=1 → FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 with result_src=01 in cycle 5; retired_cnt=1.
- sub 0x40208033 → EXECR alu_control=001, ALUWB reg_write=1; and (funct3 111) → 010; slt (funct3 010) → 101.
- beq 0x00208463 with zero=1 → pc_write=1 in BEQ; repeat with zero=0 → pc_write=0; both retire after 3 cycles.
- MEM_WAIT_EN=1, mem_ready low for 3 cycles in FETCH and MEMWRITE → ir_write/pc_write only in the ready cycle; mem_write held 4 cycles.
- op=0000000 → illegal_instr pulses 1 cycle in cycle 3, retired_cnt unchanged. Preload CNT_W=4 at 15 and retire one instruction → counter wraps to 0.
